seq_frame_tx: RTL and testbench

Serial frame transmitter for the single-line `0110` marker protocol. It emits the framed bit stream that the marker-detecting FSM receiver consumes. On a start request it latches one payload byte and drives the stream bit by bit onto `x`: the 4-bit marker `0110`, then the byte MSB-first with bit stuffing, then one guard bit. Bit stuffing guarantees that `0110` never appears on the line except as a real marker. The block sits between a byte-producing controller and the serial line, paced by a programmable bit-period divider.

---
 rtl/seq_frame_tx_if.sv | 12 +
 rtl/seq_frame_tx.sv | 137 +++++++++++++
 tb/tb_seq_frame_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_if.sv
// Byte-in / serial-line-out bundle for the 0110-marker frame transmitter.
// master = byte-producing controller side, slave = transmitter side.
interface seq_frame_tx_if;
  logic       start;
  logic [7:0] data_in;
  logic       ready;
  logic       x;
  logic       done;

  modport master (output start, data_in, input ready, x, done);
  modport slave  (input start, data_in, output ready, x, done);
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: marker 0110, payload byte MSB-first with a
// stuffed 1 after every 011 run in the payload, then one guard 1.
// Every line bit is held DIV clocks.
module seq_frame_tx #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clr_n,
  seq_frame_tx_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DMAX = CW'(DIV - 1);
  // Header bit i sits at index i (pattern is its own mirror image).
  localparam logic [3:0] HDR_BITS = 4'b0110;

  typedef enum logic [2:0] {IDLE, HDR, PAY, STUFF, GUARD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      sh;
  logic [1:0]      hidx;
  logic [3:0]      pcnt;
  logic [CW-1:0]   dcnt;
  logic [2:0]      h;
  logic            x_q, done_q;

  logic            bit_end, launch, ld, shift, x_nxt, done_nxt;

  assign bit_end   = (dcnt == DMAX);
  assign bus.ready = (state == IDLE);
  assign bus.x     = x_q;
  assign bus.done  = done_q;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the next line bit; transitions only on a divider wrap.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    ld        = 1'b0;
    shift     = 1'b0;
    x_nxt     = x_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        x_nxt = 1'b1;
        if (bus.start) begin
          ld        = 1'b1;
          launch    = 1'b1;
          x_nxt     = HDR_BITS[0];
          state_nxt = HDR;
        end
      end
      HDR: if (bit_end) begin
        launch = 1'b1;
        if (hidx == 2'd3) begin
          // First payload bit gets the same stuff test as the rest.
          if (h == 3'b011) begin
            x_nxt     = 1'b1;
            state_nxt = STUFF;
          end else begin
            x_nxt     = sh[7];
            shift     = 1'b1;
            state_nxt = PAY;
          end
        end else begin
          x_nxt = HDR_BITS[hidx + 2'd1];
        end
      end
      PAY: if (bit_end) begin
        launch = 1'b1;
        if (pcnt == 4'd8) begin
          // No stuff test before the guard: the guard 1 breaks 011 itself.
          x_nxt     = 1'b1;
          state_nxt = GUARD;
        end else if (h == 3'b011) begin
          x_nxt     = 1'b1;
          state_nxt = STUFF;
        end else begin
          x_nxt = sh[7];
          shift = 1'b1;
        end
      end
      STUFF: if (bit_end) begin
        // History now ends in 111, so the pending bit goes out unchecked.
        launch    = 1'b1;
        x_nxt     = sh[7];
        shift     = 1'b1;
        state_nxt = PAY;
      end
      GUARD: if (bit_end) begin
        x_nxt     = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        x_nxt     = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: line bit, history, divider, shifter and bit counters.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sh     <= '0;
      hidx   <= '0;
      pcnt   <= '0;
      dcnt   <= '0;
      h      <= 3'b111;
      x_q    <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= done_nxt;
      x_q    <= x_nxt;
      if (launch) h <= {h[1:0], x_nxt};
      if (state == IDLE || bit_end) dcnt <= '0;
      else                          dcnt <= dcnt + 1'b1;
      if (ld) begin
        sh   <= bus.data_in;
        hidx <= '0;
        pcnt <= '0;
      end else begin
        if (state == HDR && launch) hidx <= hidx + 2'd1;
        if (shift) begin
          sh   <= {sh[6:0], 1'b0};
          pcnt <= pcnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: DIV=1 and DIV=3 instances on one clock.
module tb_seq_frame_tx;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  seq_frame_tx_if if1();
  seq_frame_tx_if if3();

  seq_frame_tx #(.DIV(1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(if1));
  seq_frame_tx #(.DIV(3)) dut3 (.clk(clk), .clr_n(clr_n), .bus(if3));

  int nchk = 0;
  int nerr = 0;
  int sel  = 0;

  logic x_m, rdy_m, done_m;
  assign x_m    = (sel != 0) ? if3.x     : if1.x;
  assign rdy_m  = (sel != 0) ? if3.ready : if1.ready;
  assign done_m = (sel != 0) ? if3.done  : if1.done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] d);
    if (sel != 0) begin if3.start = s; if3.data_in = d; end
    else          begin if1.start = s; if1.data_in = d; end
  endtask

  // Reference receiver: skip header, drop any 1 that follows 011 in the payload.
  function automatic logic [7:0] rx_decode(input logic [31:0] b, input int n);
    logic [2:0] hh = 3'b111;
    logic [7:0] dat = '0;
    logic       bt;
    int         cnt = 0;
    for (int i = 0; i < n - 1; i++) begin
      bt = b[n-1-i];
      if (i >= 4 && cnt < 8) begin
        if (!(hh == 3'b011 && bt)) begin
          dat = {dat[6:0], bt};
          cnt++;
        end
      end
      hh = {hh[1:0], bt};
    end
    return dat;
  endfunction

  // Count 0110 windows in the frame with one idle 1 on each side.
  function automatic int markers(input logic [31:0] b, input int n);
    logic [35:0] s = '1;
    int          c = 0;
    for (int j = 1; j <= n; j++) s[j] = b[n-j];
    for (int j = 0; j <= n - 2; j++)
      if (!s[j] && s[j+1] && s[j+2] && !s[j+3]) c++;
    return c;
  endfunction

  // Send one frame, with a stray start pulse mid-frame, and check it fully.
  task automatic frame(input int s, input logic [7:0] d, input logic [31:0] exp,
                       input int nb, input string tag, output logic [31:0] seen);
    int dv, k, bad, dcount;
    logic [31:0] got;
    sel = s;
    dv  = (s != 0) ? 3 : 1;
    k = 0;
    while (!rdy_m && k < 100) begin step; k++; end
    drive(1'b1, d);
    step;
    drive(1'b0, ~d);
    k = 0; dcount = 0; bad = 0; got = '0;
    while (!rdy_m && k < 200) begin
      if (k == 5) drive(1'b1, 8'h5A);
      else if (k == 6) drive(1'b0, ~d);
      if (k < nb * dv) begin
        if (x_m !== exp[nb-1-k/dv]) bad++;
        if (k % dv == 0) got[nb-1-k/dv] = x_m;
      end
      if (done_m) dcount++;
      step;
      k++;
    end
    chk({tag, ".len"},   k, nb * dv);
    chk({tag, ".bits"},  got, exp);
    chk({tag, ".hold"},  bad, 0);
    chk({tag, ".done"},  done_m, 1'b1);
    chk({tag, ".early"}, dcount, 0);
    chk({tag, ".xidle"}, x_m, 1'b1);
    chk({tag, ".rx"},    rx_decode(got, nb), d);
    step;
    chk({tag, ".done1"}, done_m, 1'b0);
    seen = got;
  endtask

  initial begin
    logic [31:0] seen, rv, dn, got;
    if1.start = 1'b0; if1.data_in = '0;
    if3.start = 1'b0; if3.data_in = '0;

    // Reset state; start held during reset must not launch anything.
    sel = 0;
    if1.start = 1'b1; if1.data_in = 8'hA5;
    if3.start = 1'b1; if3.data_in = 8'hA5;
    step; step;
    chk("rst.x1",    if1.x, 1'b1);
    chk("rst.rdy1",  if1.ready, 1'b1);
    chk("rst.done1", if1.done, 1'b0);
    chk("rst.x3",    if3.x, 1'b1);
    chk("rst.rdy3",  if3.ready, 1'b1);
    if1.start = 1'b0; if3.start = 1'b0;
    clr_n = 1'b1;
    step;
    chk("rst.idle_x", if1.x, 1'b1);

    frame(0, 8'hA5, 32'b0110_10100101_1,        13, "a5",  seen);
    frame(0, 8'h60, 32'b0110_0111_00000_1,      14, "x60", seen);
    frame(0, 8'h36, 32'b0110_00111_0111_0_1,    15, "x36", seen);
    chk("x36.markers", markers(seen, 15), 1);
    frame(0, 8'h00, 32'b0110_00000000_1,        13, "x00", seen);
    frame(0, 8'hFF, 32'b0110_111_111111_1,      14, "xff", seen);

    // Back-to-back with start held: 0x00 then 0xFF, one idle cycle between.
    sel = 0;
    drive(1'b1, 8'h00);
    step;
    drive(1'b1, 8'hFF);
    got = '0; rv = '0; dn = '0;
    for (int k = 0; k <= 28; k++) begin
      if (k < 28) got[27-k] = x_m;
      rv[k] = rdy_m;
      dn[k] = done_m;
      if (k == 14) drive(1'b0, 8'h00);
      step;
    end
    chk("b2b.bits",  got, 32'b0110_00000000_1_1_0110_111_111111_1);
    chk("b2b.ready", rv, 32'h1000_2000);
    chk("b2b.done",  dn, 32'h1000_2000);

    frame(1, 8'hA5, 32'b0110_10100101_1,        13, "d3a5", seen);

    // Reset while payload bit b3 of 0x36 is on the line.
    sel = 0;
    drive(1'b1, 8'h36);
    step;
    drive(1'b0, 8'h00);
    repeat (9) step;
    chk("mid.b3",  x_m, 1'b0);
    chk("mid.rdy", rdy_m, 1'b0);
    clr_n = 1'b0;
    #1;
    chk("mid.x_async",   x_m, 1'b1);
    chk("mid.rdy_async", rdy_m, 1'b1);
    chk("mid.done",      done_m, 1'b0);
    step;
    chk("mid.done2", done_m, 1'b0);
    clr_n = 1'b1;
    step;
    frame(0, 8'h36, 32'b0110_00111_0111_0_1,    15, "post", seen);
    chk("post.markers", markers(seen, 15), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
